// File: rtl/dot_product_sequencer.sv
// Frame controller for the DotProductSt datapath: clears the accumulators,
// streams NUM_BEATS operand beats, waits out the arithmetic pipeline, then
// presents the captured dot product under a valid/ready handshake.
module dot_product_sequencer #(
    parameter int PIXEL_N     = 10,
    parameter int PARALLEL    = 2,
    parameter int VAL_SIZE    = 26,
    parameter int ADDR_W      = 10,
    parameter int MEM_LATENCY = 1,
    parameter int FPM_DELAY   = 6,
    parameter int FPA_DELAY   = 2
) (
    input  logic                clk,
    input  logic                GlobalReset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   frame_base,
    output logic                busy,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [PARALLEL-1:0] lane_valid,
    output logic                dp_clear,
    input  logic [VAL_SIZE-1:0] dp_value,
    output logic [VAL_SIZE-1:0] result,
    output logic                result_valid,
    input  logic                result_ready
);

    localparam int NUM_BEATS  = (PIXEL_N + PARALLEL - 1) / PARALLEL;
    // input reg, add regs and the 3-way sum interleave on top of the units
    localparam int DRAIN      = MEM_LATENCY + FPM_DELAY + FPA_DELAY + 6;
    localparam int LAST_LANES = PIXEL_N - (NUM_BEATS - 1) * PARALLEL;
    localparam int BEAT_W     = $clog2(NUM_BEATS + 1);
    localparam int DRN_W      = $clog2(DRAIN + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(NUM_BEATS - 1);
    localparam logic [DRN_W-1:0]  LAST_DRAIN = DRN_W'(DRAIN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [DRN_W-1:0]    drain_q, drain_d;
    logic [VAL_SIZE-1:0] result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic [MEM_LATENCY-1:0][PARALLEL-1:0] lv_pipe_q, lv_pipe_d;
    logic [PARALLEL-1:0] lane_pre;

    // Undelayed lane mask: full beats everywhere except a possibly partial last beat.
    for (genvar k = 0; k < PARALLEL; k++) begin : g_lane
        assign lane_pre[k] = (state_q == S_FEED) &&
                             ((beat_q != LAST_BEAT) || (k < LAST_LANES));
    end

    // Next-state, beat/drain counting and result capture.
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        beat_d         = beat_q;
        drain_d        = drain_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = frame_base;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                beat_d  = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == LAST_DRAIN) begin
                    result_d       = dp_value;
                    result_valid_d = 1'b1;
                    state_d        = S_HOLD;
                end
            end
            S_HOLD: begin
                // start is deliberately not looked at here, even when ready completes
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lane-valid delay line so the mask lines up with memory read data.
    always_comb begin
        lv_pipe_d    = lv_pipe_q;
        lv_pipe_d[0] = lane_pre;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            lv_pipe_d[i] = lv_pipe_q[i-1];
        end
    end

    // State registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q        <= S_IDLE;
            base_q         <= '0;
            beat_q         <= '0;
            drain_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            lv_pipe_q      <= '0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            beat_q         <= beat_d;
            drain_q        <= drain_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            lv_pipe_q      <= lv_pipe_d;
        end
    end

    // Outputs decode directly from registered state; address wraps modulo 2^ADDR_W.
    always_comb begin
        busy         = (state_q != S_IDLE);
        dp_clear     = (state_q == S_CLEAR);
        rd_en        = (state_q == S_FEED);
        rd_addr      = rd_en ? (base_q + ADDR_W'(beat_q)) : '0;
        lane_valid   = lv_pipe_q[MEM_LATENCY-1];
        result       = result_q;
        result_valid = result_valid_q;
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: random operands/values checked against a
// cycle-indexed frame model derived from the frame timeline.
module tb_dot_product_sequencer;

    localparam int PN = 10;
    localparam int P  = 2;
    localparam int VS = 26;
    localparam int AW = 10;
    localparam int ML = 1;
    localparam int NB = (PN + P - 1) / P;       // 5 beats
    localparam int DR = ML + 6 + 2 + 6;         // 15 drain cycles
    localparam int CAP_K = 1 + NB + DR;         // cycle whose dp_value is captured
    localparam int RV_K  = CAP_K + 1;           // first cycle result_valid is high
    localparam int GAP   = 1 + NB + DR + 2;     // start-to-start spacing when streaming

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          GlobalReset, start, start9, result_ready;
    logic [AW-1:0] frame_base;
    logic [VS-1:0] dp_value;
    logic          busy, rd_en, dp_clear, result_valid;
    logic [AW-1:0] rd_addr;
    logic [P-1:0]  lane_valid;
    logic [VS-1:0] result;
    logic          busy9, rd_en9, dp_clear9, result_valid9;
    logic [AW-1:0] rd_addr9;
    logic [P-1:0]  lane_valid9;
    logic [VS-1:0] result9;

    int n_checks = 0;
    int n_fail   = 0;
    logic [VS-1:0] dpv [0:127];

    dot_product_sequencer #(.PIXEL_N(PN), .PARALLEL(P), .VAL_SIZE(VS), .ADDR_W(AW),
                            .MEM_LATENCY(ML), .FPM_DELAY(6), .FPA_DELAY(2)) u_dut (
        .clk(clk), .GlobalReset(GlobalReset), .start(start), .frame_base(frame_base),
        .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .lane_valid(lane_valid),
        .dp_clear(dp_clear), .dp_value(dp_value), .result(result),
        .result_valid(result_valid), .result_ready(result_ready));

    dot_product_sequencer #(.PIXEL_N(9), .PARALLEL(P), .VAL_SIZE(VS), .ADDR_W(AW),
                            .MEM_LATENCY(ML), .FPM_DELAY(6), .FPA_DELAY(2)) u_dut9 (
        .clk(clk), .GlobalReset(GlobalReset), .start(start9), .frame_base(frame_base),
        .busy(busy9), .rd_en(rd_en9), .rd_addr(rd_addr9), .lane_valid(lane_valid9),
        .dp_clear(dp_clear9), .dp_value(dp_value), .result(result9),
        .result_valid(result_valid9), .result_ready(result_ready));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected lane mask in frame cycle k for an n-element dot product:
    // beat i is seen ML cycles after its read, carrying min(P, n - i*P) elements.
    function automatic logic [P-1:0] f_lane(int n, int k);
        int i = k - 2 - ML;
        int rem;
        logic [P-1:0] m = '0;
        if (i >= 0 && i < NB) begin
            rem = n - i * P;
            for (int j = 0; j < P; j++) if (j < rem) m[j] = 1'b1;
        end
        return m;
    endfunction

    task automatic test_reset();
        GlobalReset = 1'b1; start = 1'b1; start9 = 1'b1; result_ready = 1'b0;
        frame_base = 10'h155; dp_value = '1;
        step(); step();
        n_checks++;
        if ({busy, dp_clear, rd_en, result_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 0000", {busy, dp_clear, rd_en, result_valid});
        end
        n_checks++;
        if ({rd_addr, lane_valid, result} !== '0) begin
            n_fail++; $display("FAIL reset_data addr=%h lane=%b result=%h want all 0", rd_addr, lane_valid, result);
        end
        n_checks++;
        if ({busy9, result_valid9, lane_valid9} !== '0) begin
            n_fail++; $display("FAIL reset_dut9 got %b want 0", {busy9, result_valid9, lane_valid9});
        end
        GlobalReset = 1'b0; start = 1'b0; start9 = 1'b0; result_ready = 1'b1;
        step();
    endtask

    // One frame with ready held high; base may wrap.
    task automatic test_frame(input logic [AW-1:0] b, input string nm);
        logic [3:0] ectl;
        logic [AW-1:0] ea;
        for (int k = 0; k <= RV_K + 2; k++) begin
            start = (k == 0);
            frame_base = (k == 0) ? b : AW'($urandom);
            result_ready = 1'b1;
            dp_value = VS'($urandom);
            dpv[k] = dp_value;
            ectl = {(k >= 1 && k <= RV_K), (k == 1), (k >= 2 && k <= 1 + NB), (k == RV_K)};
            n_checks++;
            if ({busy, dp_clear, rd_en, result_valid} !== ectl) begin
                n_fail++; $display("FAIL %s ctrl k=%0d got %b want %b", nm, k, {busy, dp_clear, rd_en, result_valid}, ectl);
            end
            n_checks++;
            if (lane_valid !== f_lane(PN, k)) begin
                n_fail++; $display("FAIL %s lane k=%0d got %b want %b", nm, k, lane_valid, f_lane(PN, k));
            end
            if (k >= 2 && k <= 1 + NB) begin
                ea = AW'(int'(b) + k - 2);
                n_checks++;
                if (rd_addr !== ea) begin
                    n_fail++; $display("FAIL %s addr k=%0d got %h want %h", nm, k, rd_addr, ea);
                end
            end
            if (k == RV_K) begin
                n_checks++;
                if (result !== dpv[CAP_K]) begin
                    n_fail++; $display("FAIL %s result got %h want %h", nm, result, dpv[CAP_K]);
                end
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_partial_lanes();
        logic [3:0] ectl;
        for (int k = 0; k <= RV_K + 2; k++) begin
            start9 = (k == 0);
            frame_base = 10'h100;
            result_ready = 1'b1;
            dp_value = VS'($urandom);
            dpv[k] = dp_value;
            ectl = {(k >= 1 && k <= RV_K), (k == 1), (k >= 2 && k <= 1 + NB), (k == RV_K)};
            n_checks++;
            if ({busy9, dp_clear9, rd_en9, result_valid9} !== ectl) begin
                n_fail++; $display("FAIL partial ctrl k=%0d got %b want %b", k, {busy9, dp_clear9, rd_en9, result_valid9}, ectl);
            end
            n_checks++;
            if (lane_valid9 !== f_lane(9, k)) begin
                n_fail++; $display("FAIL partial lane k=%0d got %b want %b", k, lane_valid9, f_lane(9, k));
            end
            if (k == 1 + NB) begin
                n_checks++;
                if (rd_addr9 !== 10'h104) begin
                    n_fail++; $display("FAIL partial last_addr got %h want 104", rd_addr9);
                end
            end
            if (k == RV_K) begin
                n_checks++;
                if (result9 !== dpv[CAP_K]) begin
                    n_fail++; $display("FAIL partial result got %h want %h", result9, dpv[CAP_K]);
                end
            end
            step();
        end
        start9 = 1'b0;
    endtask

    // Consumer stalls 20 cycles; starts during HOLD (one coinciding with ready) are ignored.
    task automatic test_hold();
        localparam int REL = RV_K + 20;
        logic [AW-1:0] b;
        logic [3:0] ectl;
        b = AW'($urandom);
        for (int k = 0; k <= REL + 4; k++) begin
            start = (k == 0) || (k == 30) || (k == REL);
            frame_base = b;
            result_ready = (k >= REL);
            dp_value = VS'($urandom);
            dpv[k] = dp_value;
            ectl = {(k >= 1 && k <= REL), (k == 1), (k >= 2 && k <= 1 + NB), (k >= RV_K && k <= REL)};
            n_checks++;
            if ({busy, dp_clear, rd_en, result_valid} !== ectl) begin
                n_fail++; $display("FAIL hold ctrl k=%0d got %b want %b", k, {busy, dp_clear, rd_en, result_valid}, ectl);
            end
            if (k >= RV_K && k <= REL) begin
                n_checks++;
                if (result !== dpv[CAP_K]) begin
                    n_fail++; $display("FAIL hold result k=%0d got %h want %h", k, result, dpv[CAP_K]);
                end
            end
            step();
        end
        start = 1'b0;
    endtask

    // Reset on the third read beat kills the frame outright.
    task automatic test_reset_mid();
        logic [AW-1:0] b;
        b = AW'($urandom);
        for (int k = 0; k <= 40; k++) begin
            start = (k == 0);
            frame_base = b;
            result_ready = 1'b1;
            GlobalReset = (k == 4);
            dp_value = VS'($urandom);
            if (k == 4) begin
                n_checks++;
                if ({rd_en, rd_addr} !== {1'b1, AW'(b + 10'd2)}) begin
                    n_fail++; $display("FAIL rstmid beat3 got en=%b addr=%h want en=1 addr=%h", rd_en, rd_addr, AW'(b + 10'd2));
                end
            end
            if (k >= 5) begin
                n_checks++;
                if ({busy, dp_clear, rd_en, result_valid, rd_addr, lane_valid, result} !== '0) begin
                    n_fail++; $display("FAIL rstmid k=%0d busy=%b clr=%b en=%b rv=%b addr=%h lane=%b want all 0",
                                       k, busy, dp_clear, rd_en, result_valid, rd_addr, lane_valid);
                end
            end
            step();
        end
        GlobalReset = 1'b0;
    endtask

    // start held high: a new frame every GAP cycles.
    task automatic test_back_to_back();
        logic eclr, erv;
        for (int k = 0; k <= 96; k++) begin
            start = (k <= 80);
            frame_base = AW'($urandom);
            result_ready = 1'b1;
            dp_value = VS'($urandom);
            dpv[k] = dp_value;
            eclr = (k >= 1) && ((k - 1) % GAP == 0) && (k - 1 <= 80);
            erv  = (k >= RV_K) && ((k - RV_K) % GAP == 0) && (k - RV_K <= 80);
            n_checks++;
            if ({dp_clear, result_valid} !== {eclr, erv}) begin
                n_fail++; $display("FAIL b2b k=%0d clr/rv got %b want %b", k, {dp_clear, result_valid}, {eclr, erv});
            end
            if (erv) begin
                n_checks++;
                if (result !== dpv[k - 1]) begin
                    n_fail++; $display("FAIL b2b result k=%0d got %h want %h", k, result, dpv[k - 1]);
                end
            end
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        GlobalReset = 1'b1; start = 1'b0; start9 = 1'b0; result_ready = 1'b0;
        frame_base = '0; dp_value = '0;
        test_reset();
        test_frame(10'h020, "basic");
        test_partial_lanes();
        test_hold();
        test_reset_mid();
        test_frame(AW'($urandom), "after_rst");
        test_frame(10'h3FE, "wrap");
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
